regfile_snapshot_ctrl: RTL

Debug controller that freezes the single-cycle CPU on request and streams an architectural snapshot: PC, current instruction, then all 32 general registers over a valid/ready channel. It sits beside the CPU top and sequences the CPU stall line and a dedicated regfile debug read port. This replaces testbench-side hierarchical register dumps with an on-chip, synthesizable trace source.

---
 rtl/snap_pkg.sv | 23 ++
 rtl/regfile_snapshot_ctrl_if.sv | 31 +++
 rtl/snap_xor_acc.sv | 37 +++
 rtl/regfile_snapshot_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/snap_pkg.sv
// Shared types and default sizing for the register-file snapshot controller.
package snap_pkg;

  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EMIT_PC   = 3'd1,
    ST_EMIT_INST = 3'd2,
    ST_EMIT_REG  = 3'd3,
    ST_EMIT_CSUM = 3'd4
  } snap_state_t;

  typedef enum logic [1:0] {
    KIND_PC   = 2'd0,
    KIND_INST = 2'd1,
    KIND_REG  = 2'd2,
    KIND_CSUM = 2'd3
  } snap_kind_t;

endpackage

// File: rtl/regfile_snapshot_ctrl_if.sv
// Snapshot beat stream: the controller is the master, the trace sink the slave.
interface regfile_snapshot_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);

  // A beat moves on every rising edge where out_valid & out_ready. Once raised,
  // out_valid and the payload (kind/idx/data) hold until that transfer happens.
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_kind;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;

  modport master (
    output out_valid,
    output out_kind,
    output out_idx,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_kind,
    input  out_idx,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/snap_xor_acc.sv
// Running XOR of accepted snapshot beats; only present when SNAP_CHECKSUM_EN is defined.
`ifdef SNAP_CHECKSUM_EN
module snap_xor_acc #(
  parameter int DW = 32
) (
  input  logic          clk_in,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] acc_o
);

  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`endif

// File: rtl/regfile_snapshot_ctrl.sv
// Freezes the CPU and streams PC, instruction and all registers as beats.
// Optional trailing XOR checksum beat when SNAP_CHECKSUM_EN is defined.
module regfile_snapshot_ctrl
  import snap_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     snap_req,
  input  logic [DW-1:0]            cpu_pc,
  input  logic [DW-1:0]            cpu_inst,
  output logic                     cpu_stall,
  output logic [AW-1:0]            dbg_raddr,
  input  logic [DW-1:0]            dbg_rdata,
  regfile_snapshot_ctrl_if.master  snap_bus,
  output logic                     busy,
  output logic                     done,
  output snap_state_t              dbg_state
);

  snap_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] inst_q, inst_d;
  logic          done_q, done_d;

  logic          capture;
  logic          hs;
  logic          last_reg;
  logic          valid_c;
  snap_kind_t    kind_c;
  logic [AW-1:0] oidx_c;
  logic [DW-1:0] odata_c;
  logic [AW-1:0] raddr_c;

  assign hs       = snap_bus.out_valid & snap_bus.out_ready;
  assign last_reg = (idx_q == AW'(NREG - 1));

`ifdef SNAP_CHECKSUM_EN
  logic [DW-1:0] csum;
  logic          acc_en;

  assign acc_en = hs & (state_q != ST_EMIT_CSUM);

  snap_xor_acc #(.DW(DW)) u_xor_acc (
    .clk_in (clk_in),
    .reset  (reset),
    .clr_i  (capture),
    .en_i   (acc_en),
    .data_i (snap_bus.out_data),
    .acc_o  (csum)
  );
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    done_d  = 1'b0;
    capture = 1'b0;
    valid_c = 1'b0;
    kind_c  = KIND_PC;
    oidx_c  = '0;
    odata_c = '0;
    raddr_c = '0;
    case (state_q)
      ST_IDLE: begin
        if (snap_req) begin
          capture = 1'b1;
          pc_d    = cpu_pc;
          inst_d  = cpu_inst;
          idx_d   = '0;
          state_d = ST_EMIT_PC;
        end
      end
      ST_EMIT_PC: begin
        valid_c = 1'b1;
        kind_c  = KIND_PC;
        odata_c = pc_q;
        if (hs) state_d = ST_EMIT_INST;
      end
      ST_EMIT_INST: begin
        valid_c = 1'b1;
        kind_c  = KIND_INST;
        odata_c = inst_q;
        if (hs) state_d = ST_EMIT_REG;
      end
      ST_EMIT_REG: begin
        // Read data is combinational from the regfile; the stall keeps it stable.
        valid_c = 1'b1;
        kind_c  = KIND_REG;
        raddr_c = idx_q;
        oidx_c  = idx_q;
        odata_c = dbg_rdata;
        if (hs) begin
          if (last_reg) begin
            idx_d = '0;
`ifdef SNAP_CHECKSUM_EN
            state_d = ST_EMIT_CSUM;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
`ifdef SNAP_CHECKSUM_EN
      ST_EMIT_CSUM: begin
        valid_c = 1'b1;
        kind_c  = KIND_CSUM;
        odata_c = csum;
        if (hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      done_q  <= done_d;
    end
  end

  // Stalling on the request cycle keeps PC, instruction and regfile consistent
  // with what is captured on that edge.
  assign cpu_stall          = (state_q != ST_IDLE) | (snap_req & reset);
  assign busy               = (state_q != ST_IDLE);
  assign done               = done_q;
  assign dbg_raddr          = raddr_c;
  assign dbg_state          = state_q;
  assign snap_bus.out_valid = valid_c;
  assign snap_bus.out_kind  = kind_c;
  assign snap_bus.out_idx   = oidx_c;
  assign snap_bus.out_data  = odata_c;

endmodule
